// File: rtl/otopilot_kontrol_n.sv
// Altitude autopilot: fuses N altitude sensors, validates target commands, drives the motor with hysteresis, lands, and trips a climb watchdog.
// All outputs registered (one clock after the sampling edge); hedef_hazir_o is the ready for commands, which are dropped when it is low.
module otopilot_kontrol_n #(
  parameter int SENSOR_SAYISI = 2,
  parameter int W             = 16,
  parameter int H             = 8,
  parameter int HEDEF_MIN     = 10,
  parameter int HEDEF_MAX     = 100,
  parameter int SAPMA_ESIK    = 9,
  parameter int HIST          = 2,
  parameter int HATA_LIMIT    = 3,
  parameter int ZEMIN_ESIK    = 1,
  parameter int ZAMAN_ASIMI   = 1000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [SENSOR_SAYISI*W-1:0]         sensor_i,
  input  logic [H-1:0]                       hedef_i,
  input  logic                               hedef_gecerli_i,
  input  logic                               inis_i,
  output logic                               hedef_hazir_o,
  output logic                               motor_o,
  output logic                               yesil_led_o,
  output logic                               kirmizi_led_o,
  output logic [1:0]                         durum_o,
  output logic [$clog2(HATA_LIMIT+1)-1:0]    hata_sayaci_o
);

  localparam int LG = $clog2(SENSOR_SAYISI);
  localparam int SW = W + LG;
  localparam int CW = $clog2(HATA_LIMIT + 1);
  localparam int TW = $clog2(ZAMAN_ASIMI + 1);

  typedef enum logic [1:0] {
    BEKLE = 2'b00,
    ACIL  = 2'b01,
    UCUS  = 2'b10,
    INIS  = 2'b11
  } durum_t;

  durum_t          durum_q;
  logic [H-1:0]    hedef_q;
  logic [TW-1:0]   wd_q;

  logic [W-1:0]    s_min, s_max, spread, fused;
  logic [SW-1:0]   sum;
  logic [W-1:0]    hedef_w, tgt_w, esik;
  logic            cmd_ok, motor_hys, wd_trip;
  logic [CW-1:0]   hata_inc;
  logic [TW-1:0]   wd_inc;

  // Sensor fusion: average when sensors agree, otherwise trust the primary.
  always_comb begin
    s_min = sensor_i[W-1:0];
    s_max = sensor_i[W-1:0];
    sum   = SW'(sensor_i[W-1:0]);
    for (int k = 1; k < SENSOR_SAYISI; k++) begin
      if (sensor_i[k*W +: W] < s_min) s_min = sensor_i[k*W +: W];
      if (sensor_i[k*W +: W] > s_max) s_max = sensor_i[k*W +: W];
      sum = sum + SW'(sensor_i[k*W +: W]);
    end
    spread = s_max - s_min;
    if (SENSOR_SAYISI == 1 || spread > W'(SAPMA_ESIK)) fused = sensor_i[W-1:0];
    else                                                fused = W'(sum >> LG);
  end

  assign hedef_w  = W'(hedef_i);
  assign cmd_ok   = (hedef_w >= W'(HEDEF_MIN)) && (hedef_w <= W'(HEDEF_MAX));
  assign tgt_w    = W'(hedef_q);
  assign esik     = (tgt_w > W'(HIST)) ? tgt_w - W'(HIST) : '0;
  assign hata_inc = hata_sayaci_o + CW'(1);
  assign wd_inc   = wd_q + TW'(1);
  assign wd_trip  = motor_o && (wd_inc >= TW'(ZAMAN_ASIMI));

  always_comb begin
    motor_hys = motor_o;
    if (fused >= tgt_w)   motor_hys = 1'b0;
    else if (fused < esik) motor_hys = 1'b1;
  end

  assign durum_o = durum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q       <= BEKLE;
      hedef_q       <= '0;
      wd_q          <= '0;
      hedef_hazir_o <= 1'b1;
      motor_o       <= 1'b0;
      yesil_led_o   <= 1'b0;
      kirmizi_led_o <= 1'b0;
      hata_sayaci_o <= '0;
    end else begin
      case (durum_q)
        BEKLE: begin
          motor_o <= 1'b0;
          if (hedef_gecerli_i) begin
            if (cmd_ok) begin
              hedef_q <= hedef_i;
              wd_q    <= '0;
              durum_q <= UCUS;
            end else begin
              hata_sayaci_o <= hata_inc;
              if (hata_inc == CW'(HATA_LIMIT)) begin
                durum_q       <= ACIL;
                kirmizi_led_o <= 1'b1;
                hedef_hazir_o <= 1'b0;
              end
            end
          end
        end
        UCUS: begin
          if (fused >= tgt_w) yesil_led_o <= 1'b1;
          if (wd_trip) begin
            durum_q       <= ACIL;
            motor_o       <= 1'b0;
            kirmizi_led_o <= 1'b1;
            hedef_hazir_o <= 1'b0;
          end else if (inis_i) begin
            durum_q       <= INIS;
            motor_o       <= 1'b0;
            hedef_hazir_o <= 1'b0;
            wd_q          <= '0;
          end else begin
            motor_o <= motor_hys;
            wd_q    <= motor_o ? wd_inc : '0;
            if (hedef_gecerli_i) begin
              if (cmd_ok) begin
                hedef_q <= hedef_i;
                wd_q    <= '0;
              end else begin
                hata_sayaci_o <= hata_inc;
                if (hata_inc == CW'(HATA_LIMIT)) begin
                  durum_q       <= ACIL;
                  motor_o       <= 1'b0;
                  kirmizi_led_o <= 1'b1;
                  hedef_hazir_o <= 1'b0;
                end
              end
            end
          end
        end
        INIS: begin
          motor_o <= 1'b0;
          if (fused <= W'(ZEMIN_ESIK)) begin
            durum_q       <= BEKLE;
            yesil_led_o   <= 1'b0;
            hata_sayaci_o <= '0;
            hedef_q       <= '0;
            wd_q          <= '0;
            hedef_hazir_o <= 1'b1;
          end
        end
        ACIL: begin
          motor_o       <= 1'b0;
          kirmizi_led_o <= 1'b1;
          hedef_hazir_o <= 1'b0;
        end
        default: begin
          durum_q       <= BEKLE;
          motor_o       <= 1'b0;
          hedef_hazir_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otopilot_kontrol_n.sv
// Directed bench for otopilot_kontrol_n: two sensors, watchdog shortened to 8 cycles.
module tb_otopilot_kontrol_n;

  logic        clk;
  logic        rst_n;
  logic [31:0] sensor_i;
  logic [7:0]  hedef_i;
  logic        hedef_gecerli_i;
  logic        inis_i;
  logic        hedef_hazir_o;
  logic        motor_o;
  logic        yesil_led_o;
  logic        kirmizi_led_o;
  logic [1:0]  durum_o;
  logic [1:0]  hata_sayaci_o;

  int n_cmp = 0;
  int n_err = 0;

  otopilot_kontrol_n #(.ZAMAN_ASIMI(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sensor_i       (sensor_i),
    .hedef_i        (hedef_i),
    .hedef_gecerli_i(hedef_gecerli_i),
    .inis_i         (inis_i),
    .hedef_hazir_o  (hedef_hazir_o),
    .motor_o        (motor_o),
    .yesil_led_o    (yesil_led_o),
    .kirmizi_led_o  (kirmizi_led_o),
    .durum_o        (durum_o),
    .hata_sayaci_o  (hata_sayaci_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sens(input logic [15:0] s0, input logic [15:0] s1);
    sensor_i = {s1, s0};
  endtask

  task automatic cmd(input logic [7:0] h);
    hedef_i         = h;
    hedef_gecerli_i = 1'b1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_durum"}, 16'(durum_o), 16'd0);
    chk({tag, "_hazir"}, 16'(hedef_hazir_o), 16'd1);
    chk({tag, "_motor"}, 16'(motor_o), 16'd0);
    chk({tag, "_yesil"}, 16'(yesil_led_o), 16'd0);
    chk({tag, "_kirmizi"}, 16'(kirmizi_led_o), 16'd0);
    chk({tag, "_hata"}, 16'(hata_sayaci_o), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    sensor_i = '0;
    hedef_i = '0;
    hedef_gecerli_i = 1'b0;
    inis_i = 1'b0;
    #12;
    chk_reset("reset");
    rst_n = 1'b1;
    tick();

    // Fusion and climb
    sens(50, 54); cmd(60); tick();
    hedef_gecerli_i = 1'b0;
    chk("t1_ucus", 16'(durum_o), 16'd2);
    chk("t1_motor_first", 16'(motor_o), 16'd0);
    chk("t1_hazir", 16'(hedef_hazir_o), 16'd1);
    tick();
    chk("t1_motor_on", 16'(motor_o), 16'd1);
    sens(60, 60); tick();
    chk("t1_motor_off", 16'(motor_o), 16'd0);
    chk("t1_yesil", 16'(yesil_led_o), 16'd1);

    // Hysteresis around target 60 (re-enable below 58)
    sens(59, 59); tick(); chk("t2_59_hold0", 16'(motor_o), 16'd0);
    sens(57, 57); tick(); chk("t2_57_on", 16'(motor_o), 16'd1);
    sens(59, 59); tick(); chk("t2_59_hold1", 16'(motor_o), 16'd1);
    sens(60, 60); tick(); chk("t2_60_off", 16'(motor_o), 16'd0);
    chk("t2_yesil", 16'(yesil_led_o), 16'd1);

    // Sensor disagreement: retarget to 50 first
    cmd(50); tick();
    hedef_gecerli_i = 1'b0;
    chk("t3_retarget_motor", 16'(motor_o), 16'd0);
    sens(40, 80); tick(); chk("t3_fallback_on", 16'(motor_o), 16'd1);
    sens(48, 52); tick(); chk("t3_avg_off", 16'(motor_o), 16'd0);

    // Retarget to 80 and land
    sens(60, 60); cmd(80); tick();
    hedef_gecerli_i = 1'b0;
    chk("t6_motor_old_tgt", 16'(motor_o), 16'd0);
    tick();
    chk("t6_motor_new_tgt", 16'(motor_o), 16'd1);
    chk("t6_yesil_kept", 16'(yesil_led_o), 16'd1);
    inis_i = 1'b1; tick();
    chk("t6_inis", 16'(durum_o), 16'd3);
    chk("t6_inis_motor", 16'(motor_o), 16'd0);
    chk("t6_inis_hazir", 16'(hedef_hazir_o), 16'd0);
    cmd(5); tick();
    hedef_gecerli_i = 1'b0;
    chk("t6_inis_hold", 16'(durum_o), 16'd3);
    chk("t6_inis_ignore_cmd", 16'(hata_sayaci_o), 16'd0);
    inis_i = 1'b0; sens(1, 1); tick();
    chk("t6_bekle", 16'(durum_o), 16'd0);
    chk("t6_yesil_clr", 16'(yesil_led_o), 16'd0);
    chk("t6_hazir", 16'(hedef_hazir_o), 16'd1);

    // Asynchronous reset in the middle of a landing
    sens(30, 30); cmd(60); tick();
    hedef_gecerli_i = 1'b0;
    tick();
    chk("t6b_motor_on", 16'(motor_o), 16'd1);
    cmd(5); tick();
    hedef_gecerli_i = 1'b0;
    chk("t6b_hata", 16'(hata_sayaci_o), 16'd1);
    chk("t6b_still_ucus", 16'(durum_o), 16'd2);
    inis_i = 1'b1; tick();
    chk("t6b_inis", 16'(durum_o), 16'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    inis_i = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();

    // Error limit
    cmd(5); tick();
    chk("t4_hata1", 16'(hata_sayaci_o), 16'd1);
    chk("t4_bekle1", 16'(durum_o), 16'd0);
    cmd(200); tick();
    chk("t4_hata2", 16'(hata_sayaci_o), 16'd2);
    cmd(9); tick();
    chk("t4_hata3", 16'(hata_sayaci_o), 16'd3);
    chk("t4_acil", 16'(durum_o), 16'd1);
    chk("t4_kirmizi", 16'(kirmizi_led_o), 16'd1);
    chk("t4_hazir", 16'(hedef_hazir_o), 16'd0);
    cmd(50); tick();
    hedef_gecerli_i = 1'b0;
    chk("t4_acil_hold", 16'(durum_o), 16'd1);
    chk("t4_hata_hold", 16'(hata_sayaci_o), 16'd3);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    chk("t4_reset_kirmizi", 16'(kirmizi_led_o), 16'd0);
    tick();

    // Watchdog: motor rises, ACIL exactly 8 clocks later
    sens(10, 10); cmd(90); tick();
    hedef_gecerli_i = 1'b0;
    chk("t5_ucus", 16'(durum_o), 16'd2);
    tick();
    chk("t5_motor_on", 16'(motor_o), 16'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("t5_ucus_c%0d", i), 16'(durum_o), 16'd2);
    end
    tick();
    chk("t5_acil", 16'(durum_o), 16'd1);
    chk("t5_motor_off", 16'(motor_o), 16'd0);
    chk("t5_kirmizi", 16'(kirmizi_led_o), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
